// File: rtl/scan_pkg.sv
// Shared constants and the modulo index step for the display-scan counter.
package scan_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Wraps explicitly at both ends so non-power-of-two digit counts never
    // produce an out-of-range index.
    function automatic int unsigned idx_next(
        input int unsigned idx,
        input logic        dir,
        input int unsigned digits
    );
        int unsigned nxt;
        if (dir == DIR_DOWN) begin
            nxt = (idx == 0) ? (digits - 1) : (idx - 1);
        end else begin
            nxt = (idx >= digits - 1) ? 0 : (idx + 1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/scan_counter_if.sv
// Control and display-select bundle between the scan counter and its user.
interface scan_counter_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = $clog2(DIGITS);

    logic              en;
    logic              dir;
    logic              sync;
    logic [DIGITS-1:0] blank;
    logic [IDX_W-1:0]  idx;
    logic [DIGITS-1:0] an;
    logic              tick;

    modport master (
        output en, dir, sync, blank,
        input  idx, an, tick
    );

    modport slave (
        input  en, dir, sync, blank,
        output idx, an, tick
    );

endinterface

// File: rtl/scan_counter_tick_gen.sv
// Free-running N-bit prescaler with synchronous clear; flags the enabled
// cycle in which it rolls over.
module tick_gen #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] pre,
    output logic         wrap
);

    logic [N-1:0] pre_q;
    logic [N-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign pre  = pre_q;
    assign wrap = en & (pre_q == {N{1'b1}});

endmodule

// File: rtl/scan_counter.sv
// Multiplexed seven-segment scan counter: prescaled digit index, active-low
// anode decode with per-digit blanking and a one-cycle advance tick.
module scan_counter
    import scan_pkg::*;
#(
    parameter int N      = 18,
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst,
    scan_counter_if.slave  bus
);

    localparam int IDX_W = $clog2(DIGITS);

    logic             wrap;
    logic [N-1:0]     pre_unused;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             tick_q;
    logic             tick_d;

    tick_gen #(
        .N (N)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.sync),
        .pre  (pre_unused),
        .wrap (wrap)
    );

    // A restart outranks a coincident prescaler rollover: no advance that cycle.
    always_comb begin
        idx_d  = idx_q;
        tick_d = 1'b0;
        if (bus.sync) begin
            idx_d  = '0;
        end else if (wrap) begin
            idx_d  = IDX_W'(idx_next(32'(idx_q), bus.dir, DIGITS));
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            tick_q <= tick_d;
        end
    end

    assign bus.idx  = idx_q;
    assign bus.tick = tick_q;

    // Blank is applied live so a digit can be hidden without waiting for a scan step.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
            assign bus.an[gi] = ~((idx_q == IDX_W'(gi)) & ~bus.blank[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_scan_counter.sv
// Randomised and directed bench for scan_counter against an arithmetic model.
module tb_scan_counter;

    localparam int N      = 2;
    localparam int DIGITS = 3;
    localparam int PMAX   = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scan_counter_if #(.DIGITS(DIGITS)) bus ();

    scan_counter #(
        .N      (N),
        .DIGITS (DIGITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: prescaler count plus a signed net step count; digit = step mod DIGITS.
    int m_pre  = 0;
    int m_pos  = 0;
    int m_tick = 0;

    function automatic int m_idx();
        return ((m_pos % DIGITS) + DIGITS) % DIGITS;
    endfunction

    function automatic logic [DIGITS-1:0] m_an(input logic [DIGITS-1:0] b);
        logic [DIGITS-1:0] one;
        one = DIGITS'(1);
        return ~(one << m_idx()) | b;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic d, input logic s,
                         input logic [DIGITS-1:0] b);
        @(negedge clk);
        rst       = r;
        bus.en    = e;
        bus.dir   = d;
        bus.sync  = s;
        bus.blank = b;
        @(posedge clk);
        cyc++;
        if (r || s) begin
            m_pre  = 0;
            m_pos  = 0;
            m_tick = 0;
        end else if (e) begin
            if (m_pre == PMAX) begin
                m_pre  = 0;
                m_pos  = d ? m_pos - 1 : m_pos + 1;
                m_tick = 1;
            end else begin
                m_pre  = m_pre + 1;
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
        #1;
        $display("cyc %0d rst=%b en=%b dir=%b sync=%b blank=%b -> idx=%0d an=%b tick=%b",
                 cyc, r, e, d, s, b, bus.idx, bus.an, bus.tick);
        check_val("idx", 32'(bus.idx), 32'(m_idx()));
        check_val("an", 32'(bus.an), 32'(m_an(b)));
        check_val("tick", 32'(bus.tick), 32'(m_tick));
    endtask

    // Run enabled cycles until the model reaches (idx, pre); an expired bound is a failure.
    task automatic run_until(input int ti, input int tp, input logic d, input logic [DIGITS-1:0] b);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_idx() == ti && m_pre == tp) begin
                hit = 1'b1;
                break;
            end
            cycle(1'b0, 1'b1, d, 1'b0, b);
        end
        check_val("reach_state", 32'(hit), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.dir   = 1'b0;
        bus.sync  = 1'b0;
        bus.blank = '0;

        // Reset then idle: state must hold at digit 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
            check_val("idle_an", 32'(bus.an), 32'b110);
        end

        // Up scan: ticks on every 4th enabled cycle.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int c = 1; c <= 16; c++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
            check_val("up_tick_sched", 32'(bus.tick), 32'((c % 4) == 0));
        end
        check_val("up_final_idx", 32'(bus.idx), 32'd1);

        // Down scan: 0 -> 2 -> 1 -> 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int c = 1; c <= 12; c++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
            if (c == 4) check_val("down_first", 32'(bus.idx), 32'd2);
        end
        check_val("down_final_an", 32'(bus.an), 32'b110);

        // Enable gap freezes everything; tick resumes 2 enabled cycles later.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        run_until(0, 2, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_val("gap_no_tick", 32'(bus.tick), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_val("gap_resume_tick", 32'(bus.tick), 32'd1);

        // Sync coinciding with a wrap: restart wins.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        run_until(2, PMAX, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0);
        check_val("sync_idx", 32'(bus.idx), 32'd0);
        check_val("sync_tick", 32'(bus.tick), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check_val("sync_next_tick", 32'(bus.tick), 32'd1);
        check_val("sync_next_idx", 32'(bus.idx), 32'd1);

        // Blanked digit 1 during up scan, then reset mid-run.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        run_until(1, 0, 1'b0, 3'b010);
        check_val("blank_an", 32'(bus.an), 32'b111);
        run_until(2, 1, 1'b0, 3'b010);
        check_val("blank_adv_idx", 32'(bus.idx), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
        check_val("midrst_an", 32'(bus.an), 32'b110);
        check_val("midrst_idx", 32'(bus.idx), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
                  ($urandom_range(15) == 0),
                  ($urandom_range(3) == 0) ? DIGITS'($urandom) : '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
